// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter that shares one SDRAM controller slave port among NUM_M masters.
// A grant is held for the master's whole wb_cyc so bursts reach the controller uninterrupted.
module wb_sdram_arbiter #(
    parameter int unsigned NUM_M    = 4,
    parameter int unsigned dw       = 32,
    parameter int unsigned APP_AW   = 26,
    parameter int unsigned MAX_HOLD = 256
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*APP_AW-1:0] m_addr_i,
    input  logic [NUM_M*dw-1:0]     m_dat_i,
    input  logic [NUM_M*dw/8-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]      m_cti_i,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [dw-1:0]           m_dat_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [APP_AW-1:0]       s_addr_o,
    output logic [dw-1:0]           s_dat_o,
    output logic [dw/8-1:0]         s_sel_o,
    output logic [2:0]              s_cti_o,
    input  logic                    s_ack_i,
    input  logic [dw-1:0]           s_dat_i,
    output logic [NUM_M-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    starve_o
);

    localparam int unsigned LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam int unsigned SW = dw / 8;
    localparam logic [CW-1:0] MaxHold = CW'(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StGranted} state_e;

    state_e          state;
    logic [LW-1:0]   last;      // most recent grant index; equals the current master while granted
    logic [CW-1:0]   hold_cnt;
    logic [LW-1:0]   next_idx;
    logic            next_found;
    logic [LW-1:0]   cand_idx;
    int              cand;

    // First requester searching upward from last+1, wrapping.
    always_comb begin
        next_idx   = last;
        next_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= int'(NUM_M); i++) begin
            cand     = (int'(last) + i) % int'(NUM_M);
            cand_idx = LW'(cand);
            if (!next_found && m_cyc_i[cand_idx]) begin
                next_found = 1'b1;
                next_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= StIdle;
            grant_o  <= '0;
            busy_o   <= 1'b0;
            last     <= LW'(NUM_M - 1);
            hold_cnt <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    hold_cnt <= '0;
                    if (next_found) begin
                        state   <= StGranted;
                        grant_o <= {{(NUM_M-1){1'b0}}, 1'b1} << next_idx;
                        busy_o  <= 1'b1;
                        last    <= next_idx;
                    end
                end
                StGranted: begin
                    if (!m_cyc_i[last]) begin
                        state    <= StIdle;
                        grant_o  <= '0;
                        busy_o   <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != MaxHold) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_cyc_o  = busy_o & m_cyc_i[last];
        s_stb_o  = busy_o & m_cyc_i[last] & m_stb_i[last];
        s_we_o   = busy_o & m_we_i[last];
        s_addr_o = busy_o ? m_addr_i[int'(last)*APP_AW +: APP_AW] : '0;
        s_dat_o  = busy_o ? m_dat_i[int'(last)*dw +: dw] : '0;
        s_sel_o  = busy_o ? m_sel_i[int'(last)*SW +: SW] : '0;
        s_cti_o  = busy_o ? m_cti_i[int'(last)*3 +: 3] : '0;
    end

    // Gating by m_cyc_i drops an ack that lands as the master abandons its cycle.
    assign m_ack_o  = {NUM_M{s_ack_i}} & grant_o & m_cyc_i;
    assign m_dat_o  = s_dat_i;
    assign starve_o = busy_o && (hold_cnt >= MaxHold) && (|(m_cyc_i & ~grant_o));

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: a per-cycle vector table plus hand-written
// sequences for bursts, starvation and mid-cycle reset.
module tb_wb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cyc, stb, we;
    logic        ack;
    logic [31:0] sdat;

    logic [25:0] addr_arr [4];
    logic [31:0] dat_arr  [4];
    logic [3:0]  sel_arr  [4];
    logic [2:0]  cti_arr  [4];

    logic [103:0] m_addr;
    logic [127:0] m_dat;
    logic [15:0]  m_sel;
    logic [11:0]  m_cti;

    logic [3:0]  m_ack, grant;
    logic [31:0] m_dat_o, s_dat;
    logic        s_cyc, s_stb, s_we, busy, starve;
    logic [25:0] s_addr;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        m_addr = '0;
        m_dat  = '0;
        m_sel  = '0;
        m_cti  = '0;
        for (int k = 0; k < 4; k++) begin
            m_addr[k*26 +: 26] = addr_arr[k];
            m_dat[k*32 +: 32]  = dat_arr[k];
            m_sel[k*4 +: 4]    = sel_arr[k];
            m_cti[k*3 +: 3]    = cti_arr[k];
        end
    end

    wb_sdram_arbiter #(
        .NUM_M(4), .dw(32), .APP_AW(26), .MAX_HOLD(256)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_addr_i(m_addr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
        .m_ack_o(m_ack), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_dat_o(s_dat), .s_sel_o(s_sel), .s_cti_o(s_cti),
        .s_ack_i(ack), .s_dat_i(sdat),
        .grant_o(grant), .busy_o(busy), .starve_o(starve)
    );

    typedef struct {
        logic       rst;
        logic [3:0] cyc, stb, we;
        logic       ack;
        logic [3:0] eg;
        logic       eb, esc, ess;
        logic [3:0] ema;
        logic       est;
    } vec_t;

    vec_t vecs [26];

    task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] c, input logic [3:0] s,
                         input logic [3:0] w, input logic a);
        @(negedge clk);
        rst  = r;
        cyc  = c;
        stb  = s;
        we   = w;
        ack  = a;
        sdat = sdat + 32'h01010101;
        #3;
    endtask

    task automatic check(input string n, input logic [3:0] eg, input logic eb,
                         input logic esc, input logic ess, input logic [3:0] ema,
                         input logic est);
        int g;
        g = 0;
        for (int k = 0; k < 4; k++) if (eg[k]) g = k;
        cmp({n, ".grant"},  grant,  eg);
        cmp({n, ".busy"},   busy,   eb);
        cmp({n, ".s_cyc"},  s_cyc,  esc);
        cmp({n, ".s_stb"},  s_stb,  ess);
        cmp({n, ".m_ack"},  m_ack,  ema);
        cmp({n, ".starve"}, starve, est);
        cmp({n, ".s_we"},   s_we,   eb ? we[g] : 1'b0);
        cmp({n, ".s_addr"}, s_addr, eb ? addr_arr[g] : 26'h0);
        cmp({n, ".s_dat"},  s_dat,  eb ? dat_arr[g] : 32'h0);
        cmp({n, ".s_sel"},  s_sel,  eb ? sel_arr[g] : 4'h0);
        cmp({n, ".s_cti"},  s_cti,  eb ? cti_arr[g] : 3'h0);
        cmp({n, ".m_dat"},  m_dat_o, sdat);
    endtask

    initial begin
        addr_arr[0] = 26'h0000040;
        dat_arr[0]  = 32'hDEADBEEF;
        for (int k = 1; k < 4; k++) begin
            addr_arr[k] = 26'h0000040 + 26'(k * 'h100);
            dat_arr[k]  = 32'h11111111 * k;
        end
        for (int k = 0; k < 4; k++) begin
            sel_arr[k] = 4'hF >> k;
            cti_arr[k] = 3'(k);
        end
        rst  = 1'b1;
        cyc  = '0;
        stb  = '0;
        we   = '0;
        ack  = 1'b0;
        sdat = 32'h0;
        repeat (3) @(posedge clk);

        // rst, cyc, stb, we, ack, grant, busy, s_cyc, s_stb, m_ack, starve
        vecs[0]  = '{0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[1]  = '{0, 4'h1, 4'h1, 4'h1, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[2]  = '{0, 4'h1, 4'h1, 4'h1, 0, 4'h1, 1, 1, 1, 4'h0, 0};
        vecs[3]  = '{0, 4'h1, 4'h1, 4'h1, 1, 4'h1, 1, 1, 1, 4'h1, 0};
        vecs[4]  = '{0, 4'h1, 4'h0, 4'h1, 0, 4'h1, 1, 1, 0, 4'h0, 0};
        vecs[5]  = '{0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 1, 0, 0, 4'h0, 0};
        vecs[6]  = '{0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[7]  = '{1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[8]  = '{0, 4'hF, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[9]  = '{0, 4'hF, 4'hF, 4'h0, 1, 4'h1, 1, 1, 1, 4'h1, 0};
        vecs[10] = '{0, 4'hE, 4'hE, 4'h0, 1, 4'h1, 1, 0, 0, 4'h0, 0};
        vecs[11] = '{0, 4'hE, 4'hE, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[12] = '{0, 4'hE, 4'hE, 4'h0, 1, 4'h2, 1, 1, 1, 4'h2, 0};
        vecs[13] = '{0, 4'hC, 4'hC, 4'h0, 0, 4'h2, 1, 0, 0, 4'h0, 0};
        vecs[14] = '{0, 4'hC, 4'hC, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[15] = '{0, 4'hC, 4'hC, 4'h0, 1, 4'h4, 1, 1, 1, 4'h4, 0};
        vecs[16] = '{0, 4'h8, 4'h8, 4'h0, 0, 4'h4, 1, 0, 0, 4'h0, 0};
        vecs[17] = '{0, 4'h8, 4'h8, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[18] = '{0, 4'h8, 4'h8, 4'h0, 1, 4'h8, 1, 1, 1, 4'h8, 0};
        vecs[19] = '{0, 4'h1, 4'h1, 4'h0, 0, 4'h8, 1, 0, 0, 4'h0, 0};
        vecs[20] = '{0, 4'h1, 4'h1, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[21] = '{0, 4'h1, 4'h1, 4'h0, 1, 4'h1, 1, 1, 1, 4'h1, 0};
        vecs[22] = '{0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 1, 0, 0, 4'h0, 0};
        vecs[23] = '{0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[24] = '{0, 4'h0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};
        vecs[25] = '{0, 4'h0, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0, 0};

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eb, vecs[i].esc,
                  vecs[i].ess, vecs[i].ema, vecs[i].est);
        end

        // Master 1 burst with master 2 waiting; last grant was master 0.
        drive(0, 4'h6, 4'h2, 4'h0, 0);
        check("burst.req", 4'h0, 0, 0, 0, 4'h0, 0);
        for (int b = 0; b < 8; b++) begin
            cti_arr[1] = (b < 7) ? 3'b010 : 3'b111;
            drive(0, 4'h6, 4'h2, 4'h0, 1);
            check($sformatf("burst.beat%0d", b), 4'h2, 1, 1, 1, 4'h2, 0);
        end
        drive(0, 4'h4, 4'h4, 4'h0, 0);
        check("burst.drop", 4'h2, 1, 0, 0, 4'h0, 0);
        drive(0, 4'h4, 4'h4, 4'h0, 0);
        check("burst.turn", 4'h0, 0, 0, 0, 4'h0, 0);
        cti_arr[2] = 3'b010;
        drive(0, 4'h4, 4'h4, 4'h0, 1);
        check("m2.grant", 4'h4, 1, 1, 1, 4'h4, 0);

        // Reset during master 2's read burst, then a 0-versus-2 contest.
        drive(1, 4'h4, 4'h4, 4'h0, 1);
        check("rst.assert", 4'h4, 1, 1, 1, 4'h4, 0);
        drive(0, 4'h5, 4'h5, 4'h0, 1);
        check("rst.after", 4'h0, 0, 0, 0, 4'h0, 0);
        drive(0, 4'h5, 4'h5, 4'h0, 0);
        check("rst.m0wins", 4'h1, 1, 1, 1, 4'h0, 0);
        drive(0, 4'h0, 4'h0, 4'h0, 0);
        check("rst.drop", 4'h1, 1, 0, 0, 4'h0, 0);
        drive(0, 4'h0, 4'h0, 4'h0, 0);
        check("rst.idle", 4'h0, 0, 0, 0, 4'h0, 0);

        // Master 3 holds for 300 cycles while master 0 waits.
        drive(0, 4'h9, 4'h8, 4'h0, 0);
        check("hold.req", 4'h0, 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < 300; i++) begin
            drive(0, 4'h9, 4'h8, 4'h0, 0);
            check($sformatf("hold.c%0d", i), 4'h8, 1, 1, 1, 4'h0, (i >= 256) ? 1'b1 : 1'b0);
        end
        drive(0, 4'h1, 4'h1, 4'h0, 0);
        check("hold.drop", 4'h8, 1, 0, 0, 4'h0, 1);
        drive(0, 4'h1, 4'h1, 4'h0, 0);
        check("hold.idle", 4'h0, 0, 0, 0, 4'h0, 0);
        drive(0, 4'h1, 4'h1, 4'h0, 0);
        check("hold.m0", 4'h1, 1, 1, 1, 4'h0, 0);
        drive(0, 4'h0, 4'h0, 4'h0, 0);
        check("hold.end", 4'h1, 1, 0, 0, 4'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
